scanline_scheduler: RTL and testbench

- Sequences the per-scanline colour-fill engine across the full vertical extent of one triangle.
- Accepts a triangle (geometry, colour, vertex y values) from triangle setup via a valid/ready handshake and clamps the y-range to the screen.
- Issues one single-cycle color_en per row with height held stable, then waits for the engine's data_ready before advancing to the next row.
- Reports completion, rows processed, and a sticky watchdog error; supports a graceful abort.

---
 rtl/scanline_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_scanline_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_scheduler.sv
// Scanline scheduler: walks one triangle's clamped y-range, issuing one fill-engine
// row start per scanline and waiting for the engine's row-complete pulse between rows.
package scanline_scheduler_pkg;
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D v0;
        Vertex3D v1;
        Vertex3D v2;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;
endpackage

module scanline_scheduler
    import scanline_scheduler_pkg::*;
#(
    parameter int SCREEN_HEIGHT  = 480,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ROWCNT_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  Triangle3D           tri_in,
    input  Color                rgb_in,
    input  logic signed [15:0]  vy0,
    input  logic signed [15:0]  vy1,
    input  logic signed [15:0]  vy2,
    input  logic                abort,
    output logic                color_en,
    output logic signed [15:0]  height,
    output Triangle3D           ver_out,
    output Color                rgb_out,
    input  logic                data_ready,
    output logic                busy,
    output logic                tri_done,
    output logic [ROWCNT_W-1:0] rows_filled,
    output logic                timeout_err
);

    localparam int                 WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic signed [15:0] Y_LAST  = 16'(SCREEN_HEIGHT - 1);
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t                state_reg;
    logic signed [15:0]    ymax_reg;
    logic [WD_W-1:0]       watchdog_reg;
    logic                  abort_pend_reg;

    logic signed [15:0]    vy_in  [3];
    logic signed [15:0]    vy_reg [3];
    logic                  accept;

    logic signed [15:0]    ymin_raw;
    logic signed [15:0]    ymax_raw;
    logic signed [15:0]    ymin_clamp;
    logic signed [15:0]    ymax_clamp;
    logic                  off_screen;

    assign accept   = tri_valid && (state_reg == IDLE);

    assign vy_in[0] = vy0;
    assign vy_in[1] = vy1;
    assign vy_in[2] = vy2;

    // One capture register per vertex; each is only loaded on an accepted handshake.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_vy
            logic signed [15:0] vy_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vy_q <= '0;
                end else if (accept) begin
                    vy_q <= vy_in[gi];
                end
            end

            assign vy_reg[gi] = vy_q;
        end
    endgenerate

    always_comb begin
        ymin_raw = vy_reg[0];
        ymax_raw = vy_reg[0];
        for (int i = 1; i < 3; i++) begin
            if (vy_reg[i] < ymin_raw) begin
                ymin_raw = vy_reg[i];
            end
            if (vy_reg[i] > ymax_raw) begin
                ymax_raw = vy_reg[i];
            end
        end
    end

    // Off-screen is judged on the raw extremes; clamping only trims partially visible spans.
    assign ymin_clamp = (ymin_raw < 16'sd0) ? 16'sd0 : ymin_raw;
    assign ymax_clamp = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;
    assign off_screen = (ymax_raw < 16'sd0) || (ymin_raw > Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ymax_reg       <= '0;
            watchdog_reg   <= '0;
            abort_pend_reg <= 1'b0;
            height         <= '0;
            ver_out        <= '0;
            rgb_out        <= '0;
            rows_filled    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (state_reg != IDLE) begin
                abort_pend_reg <= abort_pend_reg || abort;
            end

            case (state_reg)
                IDLE: begin
                    if (tri_valid) begin
                        ver_out     <= tri_in;
                        rgb_out     <= rgb_in;
                        rows_filled <= '0;
                        timeout_err <= 1'b0;
                        state_reg   <= LOAD;
                    end
                end

                LOAD: begin
                    ymax_reg <= ymax_clamp;
                    if (off_screen || abort) begin
                        state_reg <= DONE;
                    end else begin
                        height    <= ymin_clamp;
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    watchdog_reg <= '0;
                    state_reg    <= WAIT;
                end

                WAIT: begin
                    // A row completion in the same cycle as expiry still counts as success.
                    if (data_ready) begin
                        if (rows_filled != '1) begin
                            rows_filled <= rows_filled + 1'b1;
                        end
                        state_reg <= NEXT;
                    end else if (watchdog_reg == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end

                NEXT: begin
                    if (abort_pend_reg || (height == ymax_reg)) begin
                        state_reg <= DONE;
                    end else begin
                        height    <= height + 16'sd1;
                        state_reg <= ISSUE;
                    end
                end

                DONE: begin
                    abort_pend_reg <= 1'b0;
                    state_reg      <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tri_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign color_en  = (state_reg == ISSUE);
    assign tri_done  = (state_reg == DONE);

endmodule

// File: tb/tb_scanline_scheduler.sv
// Directed bench for scanline_scheduler: a small fill-engine responder plus
// hand-computed row sequences, latencies and counters for each triangle.
module tb_scanline_scheduler;
    import scanline_scheduler_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               tri_valid;
    logic               tri_ready;
    Triangle3D          tri_in;
    Color               rgb_in;
    logic signed [15:0] vy0;
    logic signed [15:0] vy1;
    logic signed [15:0] vy2;
    logic               abort;
    logic               color_en;
    logic signed [15:0] height;
    Triangle3D          ver_out;
    Color               rgb_out;
    logic               data_ready;
    logic               busy;
    logic               tri_done;
    logic [9:0]         rows_filled;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scanline_scheduler #(
        .SCREEN_HEIGHT (480),
        .TIMEOUT_CYCLES(8),
        .ROWCNT_W      (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tri_in     (tri_in),
        .rgb_in     (rgb_in),
        .vy0        (vy0),
        .vy1        (vy1),
        .vy2        (vy2),
        .abort      (abort),
        .color_en   (color_en),
        .height     (height),
        .ver_out    (ver_out),
        .rgb_out    (rgb_out),
        .data_ready (data_ready),
        .busy       (busy),
        .tri_done   (tri_done),
        .rows_filled(rows_filled),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers one triangle, answers each row start after 'delay' cycles (0 = never),
    // optionally aborts 2 cycles into row 'abort_row' and pokes tri_valid while busy.
    task automatic run_tri(input int y0, input int y1, input int y2, input int delay,
                           input int exp_first, input int exp_n, input int exp_rows,
                           input int exp_done, input logic exp_to, input int abort_row,
                           input logic stray);
        Triangle3D t;
        Color      c;
        int        cyc;
        int        cnt;
        int        exp_h;
        int        dr_timer;
        int        ab_timer;
        logic      done_seen;

        t      = '0;
        t.v0.x = 16'(y0 + 7);
        t.v0.y = 16'(y0);
        t.v1.y = 16'(y1);
        t.v2.y = 16'(y2);
        t.v2.z = 16'h1234;
        c      = '{r: 8'hA5, g: 8'(y0), b: 8'h3C};

        tri_in    = t;
        rgb_in    = c;
        vy0       = 16'(y0);
        vy1       = 16'(y1);
        vy2       = 16'(y2);
        tri_valid = 1'b1;
        check("ready_idle", 32'(tri_ready), 32'd1);
        tick();
        tri_valid = 1'b0;
        check("busy_load", 32'(busy), 32'd1);
        check("to_cleared", 32'(timeout_err), 32'd0);
        check("rows_cleared", 32'(rows_filled), 32'd0);
        check("rgb_out", 32'(rgb_out), 32'(c));
        check("ver_out", 32'(ver_out === t), 32'd1);

        cyc       = 1;
        cnt       = 0;
        exp_h     = exp_first;
        dr_timer  = 0;
        ab_timer  = 0;
        done_seen = tri_done;
        while (!done_seen && cyc < 300) begin
            tick();
            cyc++;
            data_ready = 1'b0;
            abort      = 1'b0;
            tri_valid  = 1'b0;
            if (dr_timer > 0) begin
                dr_timer--;
                if (dr_timer == 0) data_ready = 1'b1;
            end
            if (ab_timer > 0) begin
                ab_timer--;
                if (ab_timer == 0) abort = 1'b1;
            end
            if (stray && cyc == 4) begin
                tri_valid = 1'b1;
                vy0 = 16'sd300;
                vy1 = 16'sd300;
                vy2 = 16'sd300;
            end
            if (color_en) begin
                check("height", 32'(height), 32'(exp_h));
                if (cnt == 0) check("first_lat", 32'(cyc), 32'd2);
                if (exp_h == abort_row) ab_timer = 2;
                exp_h++;
                cnt++;
                dr_timer = delay;
            end
            done_seen = tri_done;
        end
        tri_valid = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("done_cyc", 32'(cyc), 32'(exp_done));
        check("row_pulses", 32'(cnt), 32'(exp_n));
        check("rows_filled", 32'(rows_filled), 32'(exp_rows));
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
        $display("triangle vy=(%0d,%0d,%0d): rows=%0d pulses=%0d done_at=%0d timeout=%0b",
                 y0, y1, y2, rows_filled, cnt, cyc, timeout_err);
        tick();
        check("done_1cyc", 32'(tri_done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(tri_ready), 32'd1);
        check("to_sticky", 32'(timeout_err), 32'(exp_to));
    endtask

    initial begin
        rst        = 1'b1;
        tri_valid  = 1'b0;
        tri_in     = '0;
        rgb_in     = '0;
        vy0        = '0;
        vy1        = '0;
        vy2        = '0;
        abort      = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", 32'(tri_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_color_en", 32'(color_en), 32'd0);
        check("rst_done", 32'(tri_done), 32'd0);
        check("rst_rows", 32'(rows_filled), 32'd0);
        check("rst_to", 32'(timeout_err), 32'd0);
        check("rst_height", 32'(height), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'd0);

        // Stray data_ready and abort while idle must be ignored.
        data_ready = 1'b1;
        abort      = 1'b1;
        tick();
        data_ready = 1'b0;
        abort      = 1'b0;
        tick();
        check("idle_stray_rows", 32'(rows_filled), 32'd0);
        check("idle_stray_busy", 32'(busy), 32'd0);

        //      vy0  vy1  vy2 dly first n rows done to abort stray
        run_tri( 10,  12,  11, 5,  10,   3,  3, 23, 0, -1, 1);
        run_tri( -5,   2,   0, 5,   0,   3,  3, 23, 0, -1, 0);
        run_tri(470, 500, 490, 5, 470,  10, 10, 72, 0, -1, 1);
        run_tri(-20, -10,  -1, 5,   0,   0,  0,  2, 0, -1, 0);
        run_tri(480, 500, 490, 5,   0,   0,  0,  2, 0, -1, 0);
        run_tri(479, 479, 600, 5, 479,   1,  1,  9, 0, -1, 0);
        run_tri(100, 100, 100, 0, 100,   1,  0, 11, 1, -1, 0);
        run_tri(  0,   9,   5, 5,   0,   4,  4, 30, 0,  3, 0);

        // Reset in the middle of the second row's wait.
        vy0       = 16'sd10;
        vy1       = 16'sd12;
        vy2       = 16'sd11;
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        tick();
        check("mid_first_en", 32'(color_en), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        check("mid_row2_en", 32'(color_en), 32'd1);
        check("mid_row2_h", 32'(height), 32'd11);
        tick();
        check("mid_rows1", 32'(rows_filled), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ready", 32'(tri_ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_color_en", 32'(color_en), 32'd0);
        check("mrst_rows", 32'(rows_filled), 32'd0);
        $display("reset during WAIT: ready=%0b busy=%0b rows=%0d", tri_ready, busy, rows_filled);

        run_tri(  0,   0,   0, 5,   0,   1,  1,  9, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
